// File: rtl/hash_mem_pkg.sv
// hash_mem_pkg: shared FSM state type and default sizing for the hash memory responder
package hash_mem_pkg;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_NUM_NONCES = 16;
  localparam int DEF_MSG_WORDS = 20;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, COMPLETE} state_t;
endpackage

// File: rtl/hash_mem_array.sv
// hash_mem_array: single-port word RAM with registered, read-before-write output
module hash_mem_array #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0] mem [DEPTH];
  logic in_range;
  assign in_range = {16'b0, addr} < 32'(DEPTH);
  always_ff @(posedge clk)
    if (we && in_range) mem[addr[AW-1:0]] <= wdata;
  always_ff @(posedge clk)
    if (reset) rdata <= '0;
    else if (en) rdata <= in_range ? mem[addr[AW-1:0]] : '0;
endmodule

// File: rtl/hash_mem_responder.sv
// hash_mem_responder: host/engine memory mux with run FSM, result-window counter and error flags
module hash_mem_responder
  import hash_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_NONCES = DEF_NUM_NONCES,
  parameter int MSG_WORDS = DEF_MSG_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic        host_we,
  input  logic        host_re,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  output logic        host_busy,
  input  logic        go,
  input  logic [15:0] output_addr,
  output logic        results_valid,
  output logic [5:0]  write_count,
  output logic        err_range,
  output logic        err_window
);
  if (MSG_WORDS > DEPTH) begin : g_bad_msg
    $error("MSG_WORDS exceeds DEPTH");
  end
  state_t state, next_state;
  logic host_owns, eng_phase, acc_we, acc_en, oob, acc_oob, in_win;
  logic [15:0] acc_addr;
  logic [31:0] acc_wdata, rdata;
  assign host_owns = state == IDLE;
  assign eng_phase = state == WAIT_BUSY || state == RUN;
  assign acc_addr = host_owns ? host_addr : mem_addr;
  assign acc_wdata = host_owns ? host_wdata : mem_write_data;
  assign acc_we = !reset && (host_owns ? host_we : mem_we);
  assign acc_en = host_owns ? host_re && !host_we : 1'b1;
  assign oob = {16'b0, acc_addr} >= 32'(DEPTH);
  assign acc_oob = oob && (host_owns ? host_we || host_re : 1'b1);
  // 17-bit compare so a window ending past 0xFFFF never wraps onto low addresses
  assign in_win = {1'b0, mem_addr} >= {1'b0, output_addr} &&
                  {1'b0, mem_addr} < {1'b0, output_addr} + 17'(NUM_NONCES);
  assign eng_start = state == LAUNCH;
  assign host_busy = !host_owns;
  assign mem_read_data = rdata;
  assign host_rdata = rdata;
  hash_mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk(clk), .reset(reset), .en(acc_en), .we(acc_we),
    .addr(acc_addr), .wdata(acc_wdata), .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state == IDLE      ? (go ? LAUNCH : IDLE) :
                 state == LAUNCH    ? WAIT_BUSY :
                 state == WAIT_BUSY ? (eng_done ? WAIT_BUSY : RUN) :
                 state == RUN       ? (eng_done ? COMPLETE : RUN) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      host_rvalid <= 1'b0;
      write_count <= '0;
      results_valid <= 1'b0;
      err_range <= 1'b0;
      err_window <= 1'b0;
    end else begin
      host_rvalid <= host_owns && host_re && !host_we;
      if (host_owns && go) begin
        write_count <= '0;
        results_valid <= 1'b0;
        err_range <= 1'b0;
        err_window <= 1'b0;
      end else begin
        if (eng_phase && mem_we && in_win && write_count != 6'd63) write_count <= write_count + 6'd1;
        if (eng_phase && mem_we && !in_win) err_window <= 1'b1;
        if (acc_oob) err_range <= 1'b1;
        if (state == COMPLETE) results_valid <= write_count == 6'(NUM_NONCES);
      end
    end
endmodule

// File: tb/tb_hash_mem_responder.sv
// tb_hash_mem_responder: randomized scenarios checked against a word-map and window-count model
module tb_hash_mem_responder;
  logic clk = 0;
  logic reset, mem_we, eng_done, host_we, host_re, go;
  logic [15:0] mem_addr, host_addr, output_addr;
  logic [31:0] mem_write_data, host_wdata, mem_read_data, host_rdata;
  logic eng_start, host_rvalid, host_busy, results_valid, err_range, err_window;
  logic [5:0] write_count;
  int checks = 0, passed = 0;
  logic [31:0] ref_mem [int];
  int exp_count;
  bit exp_rerr, exp_werr;
  hash_mem_responder dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .eng_start(eng_start), .eng_done(eng_done), .host_we(host_we), .host_re(host_re),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .host_busy(host_busy), .go(go), .output_addr(output_addr),
    .results_valid(results_valid), .write_count(write_count),
    .err_range(err_range), .err_window(err_window)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d checks=%0d", passed, checks);
    $fatal(1);
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    host_we = 1; host_addr = a; host_wdata = d;
    cyc();
    host_we = 0;
    if (a < 256) ref_mem[int'(a)] = d;
    else exp_rerr = 1;
  endtask
  task automatic host_read(input logic [15:0] a, output logic [31:0] d, output logic v);
    host_re = 1; host_addr = a;
    cyc();
    host_re = 0;
    d = host_rdata; v = host_rvalid;
    if (a >= 256) exp_rerr = 1;
  endtask
  task automatic model_eng_write(input logic [15:0] a, input logic [31:0] d);
    if (a < 256) ref_mem[int'(a)] = d;
    else exp_rerr = 1;
    if (int'(a) >= int'(output_addr) && int'(a) < int'(output_addr) + 16)
      exp_count = exp_count < 63 ? exp_count + 1 : 63;
    else exp_werr = 1;
  endtask
  task automatic eng_write(input logic [15:0] a, input logic [31:0] d);
    mem_addr = a; mem_we = 1; mem_write_data = d;
    cyc();
    mem_we = 0; mem_addr = 0;
    model_eng_write(a, d);
  endtask
  task automatic eng_read(input logic [15:0] a, output logic [31:0] d);
    mem_addr = a;
    cyc();
    d = mem_read_data; mem_addr = 0;
    if (a >= 256) exp_rerr = 1;
  endtask
  task automatic start_run;
    go = 1;
    cyc();
    go = 0;
    exp_count = 0; exp_rerr = 0; exp_werr = 0;
    checks++; if (eng_start !== 1'b1) $display("FAIL launch_start got=%b exp=1", eng_start); else passed++;
    checks++; if (host_busy !== 1'b1) $display("FAIL launch_busy got=%b exp=1", host_busy); else passed++;
    checks++; if ({write_count, results_valid, err_range, err_window} !== 9'd0)
      $display("FAIL go_clear got cnt=%0d rv=%b er=%b ew=%b exp all 0", write_count, results_valid, err_range, err_window);
    else passed++;
    cyc();
    checks++; if (eng_start !== 1'b0) $display("FAIL start_pulse got=%b exp=0", eng_start); else passed++;
    repeat ($urandom_range(0, 2)) cyc();
    eng_done = 0;
    cyc();
    checks++; if (host_busy !== 1'b1) $display("FAIL run_busy got=%b exp=1", host_busy); else passed++;
  endtask
  task automatic end_run;
    eng_done = 1;
    cyc();
    cyc();
    checks++; if (host_busy !== 1'b0) $display("FAIL end_busy got=%b exp=0", host_busy); else passed++;
    checks++; if (write_count !== 6'(exp_count)) $display("FAIL end_count got=%0d exp=%0d", write_count, exp_count); else passed++;
    checks++; if (results_valid !== (exp_count == 16)) $display("FAIL end_rvalid got=%b exp=%b", results_valid, exp_count == 16); else passed++;
    checks++; if (err_window !== exp_werr) $display("FAIL end_errwin got=%b exp=%b", err_window, exp_werr); else passed++;
    checks++; if (err_range !== exp_rerr) $display("FAIL end_errrng got=%b exp=%b", err_range, exp_rerr); else passed++;
  endtask
  task automatic test_reset;
    reset = 1;
    cyc();
    cyc();
    checks++; if ({eng_start, host_rvalid, host_busy, results_valid, err_range, err_window} !== 6'd0)
      $display("FAIL reset_flags got=%b exp=000000", {eng_start, host_rvalid, host_busy, results_valid, err_range, err_window});
    else passed++;
    checks++; if (write_count !== 6'd0) $display("FAIL reset_count got=%0d exp=0", write_count); else passed++;
    checks++; if (mem_read_data !== 32'd0 || host_rdata !== 32'd0)
      $display("FAIL reset_data got=%h/%h exp=0", mem_read_data, host_rdata);
    else passed++;
    reset = 0;
    cyc();
  endtask
  task automatic test_host_access;
    logic [31:0] d;
    logic v;
    int keys[$];
    host_write(16'd3, 32'hDEADBEEF);
    host_read(16'd3, d, v);
    checks++; if (v !== 1'b1 || d !== 32'hDEADBEEF) $display("FAIL host_rd3 got v=%b d=%h exp v=1 d=deadbeef", v, d); else passed++;
    cyc();
    checks++; if (host_rvalid !== 1'b0) $display("FAIL rvalid_pulse got=%b exp=0", host_rvalid); else passed++;
    for (int i = 0; i < 24; i++) begin
      int a = $urandom_range(0, 255);
      host_write(16'(a), $urandom);
      keys.push_back(a);
    end
    host_write(16'd255, 32'hCAFEF00D);
    keys.push_back(255);
    for (int i = 0; i < 12; i++) begin
      int a = keys[$urandom_range(0, keys.size() - 1)];
      host_read(16'(a), d, v);
      checks++; if (v !== 1'b1 || d !== ref_mem[a]) $display("FAIL host_rand a=%0d got v=%b d=%h exp v=1 d=%h", a, v, d, ref_mem[a]); else passed++;
    end
    host_we = 1; host_re = 1; host_addr = 16'd11; host_wdata = 32'h5A5A1234;
    cyc();
    host_we = 0; host_re = 0; ref_mem[11] = 32'h5A5A1234;
    checks++; if (host_rvalid !== 1'b0) $display("FAIL we_re_rvalid got=%b exp=0", host_rvalid); else passed++;
    host_read(16'd11, d, v);
    checks++; if (d !== 32'h5A5A1234) $display("FAIL we_re_data got=%h exp=5a5a1234", d); else passed++;
    checks++; if (err_range !== 1'b0) $display("FAIL inrange_err got=%b exp=0", err_range); else passed++;
    host_write(16'd256, 32'h77777777);
    host_read(16'd256, d, v);
    checks++; if (v !== 1'b1 || d !== 32'd0) $display("FAIL host_oob got v=%b d=%h exp v=1 d=0", v, d); else passed++;
    checks++; if (err_range !== 1'b1) $display("FAIL host_oob_err got=%b exp=1", err_range); else passed++;
  endtask
  task automatic test_engine_read;
    logic [31:0] d;
    host_write(16'd5, 32'h12345678);
    output_addr = 16'h40;
    start_run();
    eng_read(16'd5, d);
    checks++; if (d !== 32'h12345678) $display("FAIL eng_rd5 got=%h exp=12345678", d); else passed++;
    for (int i = 0; i < 4; i++) begin
      int a = 3 + i * 2;
      if (ref_mem.exists(a)) begin
        eng_read(16'(a), d);
        checks++; if (d !== ref_mem[a]) $display("FAIL eng_rd a=%0d got=%h exp=%h", a, d, ref_mem[a]); else passed++;
      end
    end
    end_run();
  endtask
  task automatic test_window;
    logic [31:0] d;
    logic v;
    output_addr = 16'h40;
    start_run();
    for (int i = 0; i < 16; i++) eng_write(16'(16'h40 + i), $urandom);
    end_run();
    for (int i = 0; i < 3; i++) begin
      int a = 16'h40 + $urandom_range(0, 15);
      host_read(16'(a), d, v);
      checks++; if (d !== ref_mem[a]) $display("FAIL win_data a=%0d got=%h exp=%h", a, d, ref_mem[a]); else passed++;
    end
    for (int t = 0; t < 3; t++) begin
      int o = $urandom_range(0, 239);
      output_addr = 16'(o);
      start_run();
      for (int k = $urandom_range(12, 20); k > 0; k--) eng_write(16'(o + $urandom_range(0, 15)), $urandom);
      if (t == 2) begin
        eng_write(16'(o + 16), $urandom);
        if (o > 0) eng_write(16'(o - 1), $urandom);
      end
      end_run();
    end
    output_addr = 16'h80;
    start_run();
    for (int i = 0; i < 70; i++) eng_write(16'(16'h80 + i % 16), $urandom);
    end_run();
    output_addr = 16'hFFF8;
    start_run();
    for (int i = 0; i < 8; i++) eng_write(16'(16'hFFF8 + i), $urandom);
    eng_write(16'h0000, $urandom);
    end_run();
  endtask
  task automatic test_rbw;
    host_write(16'd7, 32'h11);
    output_addr = 16'h40;
    start_run();
    mem_addr = 16'd7; mem_we = 1; mem_write_data = 32'hAAAA0000;
    cyc();
    mem_we = 0;
    model_eng_write(16'd7, 32'hAAAA0000);
    checks++; if (mem_read_data !== 32'h11) $display("FAIL rbw_old got=%h exp=00000011", mem_read_data); else passed++;
    cyc();
    checks++; if (mem_read_data !== 32'hAAAA0000) $display("FAIL rbw_new got=%h exp=aaaa0000", mem_read_data); else passed++;
    mem_addr = 0;
    end_run();
  endtask
  task automatic test_range;
    logic [31:0] d;
    output_addr = 16'h40;
    start_run();
    eng_read(16'd300, d);
    checks++; if (d !== 32'd0) $display("FAIL eng_oob_rd got=%h exp=0", d); else passed++;
    checks++; if (err_range !== 1'b1) $display("FAIL eng_oob_err got=%b exp=1", err_range); else passed++;
    checks++; if (err_window !== 1'b0) $display("FAIL errwin_early got=%b exp=0", err_window); else passed++;
    eng_write(16'h10, $urandom);
    checks++; if (err_window !== 1'b1) $display("FAIL eng_win_err got=%b exp=1", err_window); else passed++;
    end_run();
  endtask
  task automatic test_busy_ignore;
    logic [31:0] d;
    logic v;
    host_write(16'd20, 32'h0BADF00D);
    output_addr = 16'h40;
    start_run();
    eng_write(16'h41, $urandom);
    host_we = 1; host_addr = 16'd20; host_wdata = 32'hFFFF0000;
    cyc();
    host_we = 0; host_re = 1;
    cyc();
    host_re = 0;
    checks++; if (host_rvalid !== 1'b0) $display("FAIL busy_rvalid got=%b exp=0", host_rvalid); else passed++;
    go = 1;
    cyc();
    go = 0;
    cyc();
    checks++; if (host_busy !== 1'b1 || write_count !== 6'(exp_count))
      $display("FAIL busy_go got busy=%b cnt=%0d exp busy=1 cnt=%0d", host_busy, write_count, exp_count);
    else passed++;
    end_run();
    host_read(16'd20, d, v);
    checks++; if (d !== ref_mem[20]) $display("FAIL busy_nowrite got=%h exp=%h", d, ref_mem[20]); else passed++;
  endtask
  task automatic test_go_with_write;
    logic [31:0] d;
    logic v;
    host_we = 1; host_addr = 16'd9; host_wdata = 32'h900D900D; go = 1;
    cyc();
    host_we = 0; go = 0;
    ref_mem[9] = 32'h900D900D;
    exp_count = 0; exp_rerr = 0; exp_werr = 0;
    checks++; if (eng_start !== 1'b1) $display("FAIL gowr_start got=%b exp=1", eng_start); else passed++;
    cyc();
    eng_done = 0;
    cyc();
    end_run();
    host_read(16'd9, d, v);
    checks++; if (d !== 32'h900D900D) $display("FAIL gowr_data got=%h exp=900d900d", d); else passed++;
  endtask
  task automatic test_reset_mid_run;
    logic [31:0] d;
    logic v;
    int probe[3] = '{5, 7, 16'h45};
    host_write(16'h45, 32'h45454545);
    output_addr = 16'h40;
    start_run();
    for (int i = 0; i < 4; i++) eng_write(16'(16'h40 + i), $urandom);
    reset = 1; mem_addr = 16'h45; mem_we = 1; mem_write_data = 32'hDEAD0045;
    cyc();
    reset = 0; mem_we = 0; mem_addr = 0; eng_done = 1;
    exp_count = 0; exp_rerr = 0; exp_werr = 0;
    checks++; if (host_busy !== 1'b0 || eng_start !== 1'b0) $display("FAIL rst_run_busy got busy=%b start=%b exp 0/0", host_busy, eng_start); else passed++;
    checks++; if (write_count !== 6'd0) $display("FAIL rst_run_count got=%0d exp=0", write_count); else passed++;
    checks++; if (mem_read_data !== 32'd0) $display("FAIL rst_run_rdata got=%h exp=0", mem_read_data); else passed++;
    foreach (probe[i]) begin
      host_read(16'(probe[i]), d, v);
      checks++; if (v !== 1'b1 || d !== ref_mem[probe[i]])
        $display("FAIL rst_keep a=%0d got v=%b d=%h exp v=1 d=%h", probe[i], v, d, ref_mem[probe[i]]);
      else passed++;
    end
  endtask
  initial begin
    reset = 1; mem_we = 0; eng_done = 1; host_we = 0; host_re = 0; go = 0;
    mem_addr = 0; host_addr = 0; output_addr = 0; mem_write_data = 0; host_wdata = 0;
    exp_count = 0; exp_rerr = 0; exp_werr = 0;
    test_reset();
    test_host_access();
    test_engine_read();
    test_window();
    test_rbw();
    test_range();
    test_busy_ignore();
    test_go_with_write();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/hash_mem_responder.md
HASH_MEM_RESPONDER -- requirements
Module: hash_mem_responder

Interface
REQ-001 Parameters SHALL be: DEPTH, default 256, memory size in 32-bit words; NUM_NONCES, default 16, number of expected result writes; MSG_WORDS, default 20, number of message words the host preloads.
REQ-002 clk  in  1  sole clock; every register updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Engine-side ports SHALL be: mem_addr in 16 (word address); mem_we in 1 (write strobe); mem_write_data in 32 (write data); mem_read_data out 32 (registered read data); eng_start out 1 (start pulse to the engine); eng_done in 1 (engine idle/done level).
REQ-005 Host-side ports SHALL be: host_we in 1; host_re in 1; host_addr in 16; host_wdata in 32; host_rdata out 32; host_rvalid out 1; host_busy out 1; go in 1 (run request).
REQ-006 Window and status ports SHALL be: output_addr in 16 (result window base); results_valid out 1; write_count out 6; err_range out 1 (sticky); err_window out 1 (sticky).

Function
REQ-007 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, RUN and COMPLETE.
REQ-008 IDLE: the host SHALL own the memory port and host_busy SHALL be 0; go=1 SHALL move the FSM to LAUNCH.
REQ-009 LAUNCH: eng_start SHALL be 1 for exactly one cycle, then the FSM SHALL move to WAIT_BUSY.
REQ-010 WAIT_BUSY: the FSM SHALL stay until eng_done=0, then move to RUN; there is no timeout.
REQ-011 RUN: the FSM SHALL stay until eng_done=1, then move to COMPLETE.
REQ-012 COMPLETE (one cycle): results_valid SHALL be set if write_count==NUM_NONCES, otherwise cleared; the FSM SHALL then move to IDLE.
REQ-013 In every state other than IDLE, the engine SHALL own the memory port, host_busy SHALL be 1, and host_we/host_re SHALL be ignored with no memory change and no rvalid.
REQ-014 Engine read: mem_read_data SHALL equal mem[mem_addr] as sampled at edge N and SHALL be valid after edge N (one-cycle latency), held until the next sample.
REQ-015 Engine write: mem_we=1 SHALL write mem_write_data to mem[mem_addr] at the edge.
REQ-016 Read and write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-017 Host access: host_we SHALL write host_wdata; host_re SHALL produce host_rdata with host_rvalid=1 exactly one cycle later.
REQ-018 If host_we and host_re are both 1, the write SHALL win and host_rvalid SHALL stay 0.
REQ-019 go together with host_we in IDLE: the write SHALL complete and go SHALL also be accepted.
REQ-020 Address >= DEPTH from either port: a read SHALL return 0, a write SHALL be dropped, and err_range SHALL be set.
REQ-021 In WAIT_BUSY/RUN, a write with address in [output_addr, output_addr+NUM_NONCES-1] SHALL increment write_count, saturating at 63; any other engine write SHALL set err_window and still be performed if in range.
REQ-022 Window arithmetic SHALL use 17 bits, so a window that crosses 0xFFFF does not wrap.
REQ-023 Accepting go SHALL clear write_count, results_valid, err_range and err_window.
REQ-024 go outside IDLE SHALL be ignored.

Reset
REQ-025 reset=1 SHALL force the FSM to IDLE, set eng_start, host_rvalid, host_busy, results_valid, err_range and err_window to 0, set write_count to 0, and set mem_read_data and host_rdata to 0.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 Reset mid-RUN SHALL take priority over every other event in the same cycle, and any write in that cycle SHALL be dropped.

Structure
REQ-028 A shared package hash_mem_pkg SHALL hold the state enum and the default DEPTH, NUM_NONCES and MSG_WORDS constants.
REQ-029 Storage SHALL be a single-port synchronous RAM sub-module hash_mem_array (registered read, read-before-write).
REQ-030 The top level SHALL contain the port mux, the FSM, the window counter and the error flags.

Verification
REQ-031 Host write addr 3=0xDEADBEEF, then host_re addr 3 -> host_rvalid=1 and host_rdata=0xDEADBEEF one cycle later.
REQ-032 Preload addr 5=0x12345678; engine stub drives mem_addr=5 in RUN -> mem_read_data=0x12345678 on the next cycle.
REQ-033 output_addr=0x40, go, stub drops eng_done 2 cycles after start, writes 0x40..0x4F, raises eng_done -> results_valid=1, write_count=16, FSM back in IDLE.
REQ-034 Same-cycle engine write 0xAAAA0000 and read at addr 7 (old value 0x11) -> read returns 0x11; a following read returns 0xAAAA0000.
REQ-035 Engine access to addr 300 with DEPTH=256 -> read 0, err_range=1; a write to 0x10 with output_addr=0x40 -> err_window=1.
REQ-036 Assert reset mid-RUN -> FSM in IDLE, host_busy=0, write_count=0, previously preloaded words still readable.
